gray_frame_writer: RTL and testbench
====================================

# gray_frame_writer

Upstream producer for an SRAM arbiter write port. Accepts a 24-bit RGB pixel stream (ready/valid), reduces each pixel to 8-bit grey, packs four grey pixels per 32-bit SRAM word and emits `{mask, addr, data}` write commands into one of two frame buffers. Frame start and end are sequenced by the swap controller through four-phase start/done handshakes. It produces the grey image that the SIFT pipeline and the image-buffer reader consume.

## Interface
- `N_PIXEL`, 480000: pixels per frame (800x600).
- `BASE0`, 18'h00000: word base address of buffer 0.
- `BASE1`, 18'h20000: word base address of buffer 1.

- `clock`  in  1  sole clock; every register is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request from the swap controller.
- `start_ack`  out  1  frame request acknowledge.
- `done`  out  1  frame fully written.
- `done_ack`  in  1  done acknowledge.
- `buffer_sel`  in  1  target buffer. Sampled only in IDLE, when `start`=1.
- `pix_in`  in  24  pixel `{R[23:16], G[15:8], B[7:0]}`.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  block accepts `pix_in` this cycle.
- `dout`  out  54  `{mask[53:50], addr[49:32], data[31:0]}`. A mask bit of 1 means that byte is written.
- `valid`  out  1  `dout` is valid.
- `ready`  in  1  arbiter accepts `dout`.

## Operation
- FSM states: IDLE, ACK, RUN, FLUSH, DONE. Reset state is IDLE.
- IDLE: when `start`=1, latch `buffer_sel` into `sel_q`, clear the pixel and word counters and the lane index, then go to ACK.
- ACK: `start_ack`=1. When `start`=0, go to RUN.
- RUN:
  - `pix_ready` = (`pix_cnt` < N_PIXEL) && (lane != 3 || !`valid` || `ready`).
  - A pixel is accepted on `pix_valid && pix_ready`.
  - Grey byte `g` goes into byte lane `lane`: lane 0 is `data[7:0]`, lane 3 is `data[31:24]`.
  - Lane index advances modulo 4. `pix_cnt` increments by 1.
  - On acceptance into lane 3: load the output register with `mask`=4'hF, `addr`=base+`word_cnt`, and data = the three held lanes plus `g`; set `valid`=1; `word_cnt`++.
  - When `pix_cnt` reaches N_PIXEL, go to FLUSH.
- FLUSH:
  - If lane != 0, issue one partial word with mask bits [lane-1:0] set, unused bytes 0. It loads as soon as the output register is free.
  - Once the output register is empty (last word accepted), go to DONE.
- DONE: `done`=1 until `done_ack`=1. Then drop `done` and wait for `done_ack`=0 before returning to IDLE.
- Output register: `valid` clears on `valid && ready` unless it is reloaded in the same cycle. `dout` is held stable while `valid && !ready`.
- Address arithmetic: base = `sel_q` ? BASE1 : BASE0. `addr` = base + `word_cnt`, 18 bits, wraps modulo 2^18 with no flag. `word_cnt` is 18 bits.
- `pix_ready`=0 in every state except RUN. `start` changes outside IDLE/ACK and `done_ack` changes outside DONE are ignored.
- Reset outputs: `start_ack`=0, `done`=0, `pix_ready`=0, `valid`=0, `dout`=0.
- `reset_n` low at any time returns the block to IDLE immediately and discards any partial word and any pending output word.

## Timing
- One pixel per cycle sustained while `ready`=1.
- A lane-3 pixel accepted at edge k gives `valid`=1 from edge k (visible in cycle k+1).
- `start`↑ gives `start_ack`↑ one edge later.
- Final word accepted at edge k → `done`=1 after edge k+1.
- `done_ack`↑ gives `done`↓ one edge later.
- Grey conversion is combinational on `pix_in` and captured at acceptance. No extra pipeline stage.

## Configuration
- `LUMA_CONVERT_EN` defined: `g` = (77·R + 150·G + 29·B) >> 8. The sum is 16 bits unsigned and the result is truncated to 8 bits (max 255).
- `LUMA_CONVERT_EN` undefined: `g` = G. No multipliers are instantiated.
- Interface and timing are identical in both builds.

## Test plan
- N_PIXEL=8, `buffer_sel`=1, pixels 0x000000..0x070707 (all channels equal to the index), `ready`=1 → two words: `dout`={F, 0x20000, 0x03020100}, then {F, 0x20001, 0x07060504}. Then `done`=1. In both builds `g` equals the channel value.
- N_PIXEL=6, `buffer_sel`=0 → second word is {4'h3, 0x00001, 0x00000504}. Exactly two words are issued.
- Stall: hold `ready`=0 for 5 cycles while `valid`=1 → `dout` stable throughout. `pix_ready`=0 once lane 3 is pending. After `ready`=1, no pixel is lost or duplicated.
- With `LUMA_CONVERT_EN`, pixel 0xFF0000 → byte 0x4C. Pixel 0xFFFFFF → 0xFF. Without the macro, 0x12AB34 → 0xAB.
- Handshake: `start` held 3 cycles → `start_ack` high until 1 cycle after `start`↓. `done` stays high until `done_ack`. A second `start` while `done_ack` is still high is not accepted.
- Reset: pulse `reset_n` low mid-frame (after pixel 5) → all outputs 0, state IDLE. The next frame starts at base+0 with lane 0.

Source files
------------

// File: rtl/gray_frame_writer.sv
// gray_frame_writer: turns a 24-bit RGB pixel stream into 8-bit grey and packs
// four grey bytes per 32-bit SRAM word. It emits {mask, addr, data} write commands
// into one of two frame buffers. Frame start/end use four-phase handshakes with the
// swap controller.
// Optional build macro: LUMA_CONVERT_EN selects weighted luma instead of green passthrough.
module gray_frame_writer #(
    parameter int          N_PIXEL = 480000,
    parameter logic [17:0] BASE0   = 18'h00000,
    parameter logic [17:0] BASE1   = 18'h20000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        start_ack,
    output logic        done,
    input  logic        done_ack,
    input  logic        buffer_sel,
    input  logic [23:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [53:0] dout,
    output logic        valid,
    input  logic        ready
);

    localparam int CNT_W = $clog2(N_PIXEL + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(N_PIXEL);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_PIXEL - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] pix_cnt;
    logic [17:0]      word_cnt;
    logic [1:0]       lane;
    logic [23:0]      held;
    logic             sel_q;
    logic             ack_seen;
    logic [7:0]       g;
    logic             out_free;
    logic             accept;
    logic             load_full;
    logic             load_part;
    logic [17:0]      base;
    logic [3:0]       part_mask;
    logic [31:0]      part_data;

`ifdef LUMA_CONVERT_EN
    logic [15:0] luma_sum;

    // Weighted luma; the weights sum to 256 so the top byte never overflows.
    always_comb begin
        luma_sum = 16'd77  * 16'(pix_in[23:16])
                 + 16'd150 * 16'(pix_in[15:8])
                 + 16'd29  * 16'(pix_in[7:0]);
        g = luma_sum[15:8];
    end
`else
    logic unused_channels;

    // Green channel passthrough; red and blue are deliberately unused in this build.
    always_comb begin
        g = pix_in[15:8];
        unused_channels = ^{pix_in[23:16], pix_in[7:0]};
    end
`endif

    // Handshake strobes for the pixel input, the output register and the partial-word flush.
    always_comb begin
        out_free  = !valid || ready;
        pix_ready = (state == RUN) && (pix_cnt < LIMIT) && ((lane != 2'd3) || out_free);
        accept    = pix_valid && pix_ready;
        load_full = accept && (lane == 2'd3);
        load_part = (state == FLUSH) && (lane != 2'd0) && out_free;
        base      = sel_q ? BASE1 : BASE0;
        case (lane)
            2'd1:    part_mask = 4'b0001;
            2'd2:    part_mask = 4'b0011;
            2'd3:    part_mask = 4'b0111;
            default: part_mask = 4'b0000;
        endcase
        part_data = {8'h00, held & {{8{part_mask[2]}}, {8{part_mask[1]}}, {8{part_mask[0]}}}};
    end

    // Frame sequencer state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the start/done handshake outputs.
    always_comb begin
        state_next = state;
        start_ack  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                start_ack = 1'b1;
                if (!start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if ((pix_cnt >= LIMIT) || (accept && (pix_cnt == LAST))) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if ((lane == 2'd0) && !valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = !ack_seen;
                if (ack_seen && !done_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pixel packing, counters and the output command register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt  <= '0;
            word_cnt <= '0;
            lane     <= '0;
            held     <= '0;
            sel_q    <= 1'b0;
            ack_seen <= 1'b0;
            dout     <= '0;
            valid    <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                sel_q    <= buffer_sel;
                pix_cnt  <= '0;
                word_cnt <= '0;
                lane     <= '0;
            end

            if (state == IDLE) begin
                ack_seen <= 1'b0;
            end else if ((state == DONE) && done_ack) begin
                ack_seen <= 1'b1;
            end

            if (accept) begin
                pix_cnt <= pix_cnt + 1'b1;
                lane    <= lane + 2'd1;
                case (lane)
                    2'd0:    held[7:0]   <= g;
                    2'd1:    held[15:8]  <= g;
                    2'd2:    held[23:16] <= g;
                    default: ;
                endcase
            end

            if (load_full) begin
                dout     <= {4'hF, base + word_cnt, g, held};
                word_cnt <= word_cnt + 18'd1;
            end else if (load_part) begin
                dout     <= {part_mask, base + word_cnt, part_data};
                word_cnt <= word_cnt + 18'd1;
                lane     <= 2'd0;
            end

            if (load_full || load_part) begin
                valid <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gray_frame_writer.sv
// Testbench for gray_frame_writer: two instances (8- and 6-pixel frames) share
// stimulus; a reference model pushes expected words as pixels are accepted and
// each scenario task compares them against the captured output words.
module tb_gray_frame_writer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        buffer_sel;
    logic [23:0] pix_in;
    logic        pix_valid;
    logic        done_ack;
    logic        ready;

    logic        start_ack8, done8, pix_ready8, valid8;
    logic [53:0] dout8;
    logic        start_ack6, done6, pix_ready6, valid6;
    logic [53:0] dout6;

    logic        use6;
    logic        act_start_ack, act_done, act_pix_ready, act_valid;
    logic [53:0] act_dout;

    int errors = 0;
    int checks = 0;

    logic [53:0] exp_q[$];
    logic [53:0] got_q[$];
    logic [23:0] stim_q[$];

    int          m_lane;
    logic [17:0] m_word;
    logic [17:0] m_base;
    logic [23:0] m_data;

`ifdef LUMA_CONVERT_EN
    localparam logic [31:0] CONV_WORD = 32'h006FFF4C;
`else
    localparam logic [31:0] CONV_WORD = 32'h00ABFF00;
`endif

    gray_frame_writer #(.N_PIXEL(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start), .start_ack(start_ack8),
        .done(done8), .done_ack(done_ack), .buffer_sel(buffer_sel), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready8), .dout(dout8), .valid(valid8),
        .ready(ready)
    );

    gray_frame_writer #(.N_PIXEL(6)) dut6 (
        .clock(clock), .reset_n(reset_n), .start(start), .start_ack(start_ack6),
        .done(done6), .done_ack(done_ack), .buffer_sel(buffer_sel), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready6), .dout(dout6), .valid(valid6),
        .ready(ready)
    );

    assign act_start_ack = use6 ? start_ack6 : start_ack8;
    assign act_done      = use6 ? done6      : done8;
    assign act_pix_ready = use6 ? pix_ready6 : pix_ready8;
    assign act_valid     = use6 ? valid6     : valid8;
    assign act_dout      = use6 ? dout6      : dout8;

    always #5 clock = ~clock;

    function automatic logic [7:0] grey_of(input logic [23:0] p);
`ifdef LUMA_CONVERT_EN
        int s;
        s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
        return 8'(s / 256);
`else
        return p[15:8];
`endif
    endfunction

    task automatic model_accept(input logic [23:0] p);
        logic [7:0] gv;
        gv = grey_of(p);
        if (m_lane == 3) begin
            exp_q.push_back({4'hF, 18'(m_base + m_word), gv, m_data});
            m_word = m_word + 18'd1;
            m_lane = 0;
        end else begin
            m_data[m_lane*8 +: 8] = gv;
            m_lane = m_lane + 1;
        end
    endtask

    task automatic model_flush();
        logic [31:0] d;
        logic [3:0]  mk;
        if (m_lane != 0) begin
            d = {8'h00, m_data};
            for (int b = m_lane; b < 4; b++) d[b*8 +: 8] = 8'h00;
            mk = 4'((1 << m_lane) - 1);
            exp_q.push_back({mk, 18'(m_base + m_word), d});
            m_word = m_word + 18'd1;
            m_lane = 0;
        end
    endtask

    // One clock: sample just after inputs were set at the falling edge, then step.
    task automatic tick();
        #1;
        if (act_valid && ready) got_q.push_back(act_dout);
        if (pix_valid && act_pix_ready) begin
            model_accept(pix_in);
            if (stim_q.size() > 0) void'(stim_q.pop_front());
        end
        @(negedge clock);
        if (stim_q.size() > 0) pix_in = stim_q[0];
        else pix_in = 24'h0;
    endtask

    task automatic do_reset(input logic which6);
        use6 = which6;
        reset_n = 1'b0;
        start = 1'b0;
        buffer_sel = 1'b0;
        pix_valid = 1'b0;
        done_ack = 1'b0;
        ready = 1'b1;
        pix_in = 24'h0;
        exp_q.delete();
        got_q.delete();
        stim_q.delete();
        m_lane = 0;
        m_word = '0;
        m_base = '0;
        m_data = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic start_frame(input logic sel);
        buffer_sel = sel;
        start = 1'b1;
        m_base = sel ? 18'h20000 : 18'h00000;
        m_lane = 0;
        m_word = '0;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic load_ramp(input int n);
        for (int i = 0; i < n; i++) stim_q.push_back({3{8'(i)}});
        pix_in = stim_q[0];
    endtask

    task automatic send_all(input int budget, output bit timed_out);
        int n;
        n = 0;
        while (stim_q.size() > 0 && n < budget) begin
            pix_valid = 1'b1;
            tick();
            n++;
        end
        pix_valid = 1'b0;
        timed_out = (stim_q.size() > 0);
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int n;
        n = 0;
        while (!act_done && n < budget) begin
            tick();
            n++;
        end
        timed_out = !act_done;
    endtask

    task automatic test_reset();
        use6 = 1'b0;
        reset_n = 1'b0;
        tick();
        checks++;
        if ({start_ack8, done8, pix_ready8, valid8} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags8: got %b expected 0000", {start_ack8, done8, pix_ready8, valid8});
        end
        checks++;
        if (dout8 !== 54'h0) begin
            errors++;
            $display("[TB] FAIL reset_dout8: got %h expected 0", dout8);
        end
        checks++;
        if ({start_ack6, done6, pix_ready6, valid6, dout6} !== 58'h0) begin
            errors++;
            $display("[TB] FAIL reset_all6: got %h expected 0", {start_ack6, done6, pix_ready6, valid6, dout6});
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if ({start_ack8, pix_ready8} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %b expected 00", {start_ack8, pix_ready8});
        end
    endtask

    task automatic test_handshake();
        do_reset(1'b0);
        start = 1'b1;
        tick();
        checks++;
        if (act_start_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_ack_rise: got %b expected 1", act_start_ack);
        end
        tick();
        tick();
        checks++;
        if (act_start_ack !== 1'b1 || act_pix_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_ack_hold: got ack=%b rdy=%b expected ack=1 rdy=0", act_start_ack, act_pix_ready);
        end
        start = 1'b0;
        #1;
        checks++;
        if (act_start_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_ack_after_fall: got %b expected 1", act_start_ack);
        end
        tick();
        checks++;
        if (act_start_ack !== 1'b0 || act_pix_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_entry: got ack=%b rdy=%b expected ack=0 rdy=1", act_start_ack, act_pix_ready);
        end
    endtask

    task automatic test_frame8();
        bit to;
        do_reset(1'b0);
        start_frame(1'b1);
        load_ramp(8);
        send_all(100, to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL frame8_pixels: got %0d left expected 0", stim_q.size());
        end
        checks++;
        if (act_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame8_done_early: got %b expected 0", act_done);
        end
        tick();
        checks++;
        if (act_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame8_done_edge1: got %b expected 0", act_done);
        end
        tick();
        checks++;
        if (act_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame8_done_edge2: got %b expected 1", act_done);
        end
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL frame8_count: got %0d expected 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {4'hF, 18'h20000, 32'h03020100}) begin
                errors++;
                $display("[TB] FAIL frame8_word0: got %h expected %h", got_q[0], {4'hF, 18'h20000, 32'h03020100});
            end
            checks++;
            if (got_q[1] !== {4'hF, 18'h20001, 32'h07060504}) begin
                errors++;
                $display("[TB] FAIL frame8_word1: got %h expected %h", got_q[1], {4'hF, 18'h20001, 32'h07060504});
            end
        end
        tick();
        checks++;
        if (act_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_holds: got %b expected 1", act_done);
        end
        done_ack = 1'b1;
        tick();
        checks++;
        if (act_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_drop: got %b expected 0", act_done);
        end
        start = 1'b1;
        tick();
        tick();
        checks++;
        if (act_start_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_during_done_ack: got %b expected 0", act_start_ack);
        end
        done_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (act_start_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_after_done_ack: got %b expected 1", act_start_ack);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_frame6();
        bit to;
        logic [53:0] gw, ew;
        do_reset(1'b1);
        start_frame(1'b0);
        load_ramp(6);
        send_all(100, to);
        wait_done(20, to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL frame6_done_timeout: got done=%b expected 1", act_done);
        end
        tick();
        tick();
        model_flush();
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL frame6_count: got %0d expected 2", got_q.size());
        end else begin
            checks++;
            if (got_q[1] !== {4'h3, 18'h00001, 32'h00000504}) begin
                errors++;
                $display("[TB] FAIL frame6_partial: got %h expected %h", got_q[1], {4'h3, 18'h00001, 32'h00000504});
            end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            gw = got_q.pop_front();
            ew = exp_q.pop_front();
            checks++;
            if (gw !== ew) begin
                errors++;
                $display("[TB] FAIL frame6_word: got %h expected %h", gw, ew);
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        int n;
        logic [53:0] held, gw, ew;
        do_reset(1'b0);
        start_frame(1'b0);
        for (int i = 0; i < 8; i++) stim_q.push_back(24'($urandom));
        pix_in = stim_q[0];
        ready = 1'b0;
        n = 0;
        while (!act_valid && n < 20) begin
            pix_valid = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (!act_valid) begin
            errors++;
            $display("[TB] FAIL stall_first_word: got valid=%b expected 1", act_valid);
        end
        held = act_dout;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (act_dout !== held || act_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold: got %h valid=%b expected %h valid=1", act_dout, act_valid, held);
            end
        end
        checks++;
        if (act_pix_ready !== 1'b0 || stim_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL stall_backpressure: got rdy=%b left=%0d expected rdy=0 left=1", act_pix_ready, stim_q.size());
        end
        ready = 1'b1;
        send_all(50, to);
        wait_done(20, to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL stall_done_timeout: got done=%b expected 1", act_done);
        end
        model_flush();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            gw = got_q.pop_front();
            ew = exp_q.pop_front();
            checks++;
            if (gw !== ew) begin
                errors++;
                $display("[TB] FAIL stall_word: got %h expected %h", gw, ew);
            end
        end
    endtask

    task automatic test_convert();
        bit to;
        logic [53:0] gw, ew;
        do_reset(1'b0);
        start_frame(1'b0);
        stim_q.push_back(24'hFF0000);
        stim_q.push_back(24'hFFFFFF);
        stim_q.push_back(24'h12AB34);
        stim_q.push_back(24'h000000);
        for (int i = 0; i < 4; i++) stim_q.push_back(24'h102030);
        pix_in = stim_q[0];
        send_all(100, to);
        wait_done(20, to);
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL convert_count: got %0d expected 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {4'hF, 18'h00000, CONV_WORD}) begin
                errors++;
                $display("[TB] FAIL convert_bytes: got %h expected %h", got_q[0], {4'hF, 18'h00000, CONV_WORD});
            end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            gw = got_q.pop_front();
            ew = exp_q.pop_front();
            checks++;
            if (gw !== ew) begin
                errors++;
                $display("[TB] FAIL convert_word: got %h expected %h", gw, ew);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        int n;
        logic [53:0] gw, ew;
        do_reset(1'b0);
        start_frame(1'b1);
        for (int i = 0; i < 8; i++) stim_q.push_back({3{8'(8'h40 + i)}});
        pix_in = stim_q[0];
        n = 0;
        while (stim_q.size() > 2 && n < 50) begin
            pix_valid = 1'b1;
            tick();
            n++;
        end
        ready = 1'b0;
        pix_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({act_start_ack, act_done, act_pix_ready, act_valid, act_dout} !== 58'h0) begin
            errors++;
            $display("[TB] FAIL midframe_reset: got %h expected 0",
                     {act_start_ack, act_done, act_pix_ready, act_valid, act_dout});
        end
        do_reset(1'b0);
        start_frame(1'b1);
        for (int i = 0; i < 8; i++) stim_q.push_back({3{8'(8'h80 + 3 * i)}});
        pix_in = stim_q[0];
        send_all(100, to);
        wait_done(20, to);
        checks++;
        if (to || got_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL after_reset_frame: got %0d words done=%b expected 2 words done=1", got_q.size(), act_done);
        end else begin
            checks++;
            if (got_q[0][49:32] !== 18'h20000) begin
                errors++;
                $display("[TB] FAIL after_reset_addr: got %h expected 20000", got_q[0][49:32]);
            end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            gw = got_q.pop_front();
            ew = exp_q.pop_front();
            checks++;
            if (gw !== ew) begin
                errors++;
                $display("[TB] FAIL after_reset_word: got %h expected %h", gw, ew);
            end
        end
    endtask

    // Scenario sequence; every scenario starts from its own reset.
    initial begin
        use6 = 1'b0;
        reset_n = 1'b0;
        start = 1'b0;
        buffer_sel = 1'b0;
        pix_in = 24'h0;
        pix_valid = 1'b0;
        done_ack = 1'b0;
        ready = 1'b1;
        m_lane = 0;
        m_word = '0;
        m_base = '0;
        m_data = '0;
        @(negedge clock);
        test_reset();
        test_handshake();
        test_frame8();
        test_frame6();
        test_stall();
        test_convert();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
